// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle wide adder built around one 4-bit carry-lookahead slice
//
// Purpose:
//   Adds two WIDTH-bit operands by sequencing a single 4-bit carry-lookahead
//   slice over N = WIDTH/4 cycles. It processes one nibble per cycle, starting
//   with the least-significant nibble. A registered carry links each nibble to
//   the next one. Operation is controlled by a start/busy/done handshake.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   When CLA_SEQ_SUB_EN is defined, the sub port is present. With sub=1 the
//   block computes a - b. Without the macro the block only adds.
//
// Parameters:
//   WIDTH    operand/result width; a multiple of 4, at least 4 (default 16)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, sampled only while idle
//   a, b     in   operands, latched on an accepted start
//   cin      in   carry-in, latched on an accepted start
//   sub      in   subtract select (CLA_SEQ_SUB_EN only)
//   busy     out  high while an operation is in progress
//   done     out  one-cycle pulse when sum/cout become valid
//   sum      out  result register
//   cout     out  carry out of bit WIDTH-1 (with sub=1, 1 means no borrow)

module cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is expanded directly from generate/propagate terms.
    // This keeps every carry two logic levels deep instead of rippling.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef CLA_SEQ_SUB_EN
    logic             r_sub;
`endif

    logic [3:0] w_a_nib;
    logic [3:0] w_b_raw;
    logic [3:0] w_b_nib;
    logic [3:0] w_nib_sum;
    logic       w_nib_cout;

    // Nibble base bit index is cnt*4, formed by appending two zero bits.
    assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b_raw = r_b[{r_cnt, 2'b00} +: 4];

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is done as two's complement: invert B here, and the
    // initial carry is forced to 1 when the operation is accepted.
    assign w_b_nib = r_sub ? ~w_b_raw : w_b_raw;
`else
    assign w_b_nib = w_b_raw;
`endif

    cla u_cla (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start in the done cycle is accepted here as well,
                    // so operations can run back to back.
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
`ifdef CLA_SEQ_SUB_EN
                        r_sub   <= sub;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_carry <= cin;
`endif
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_nib_sum;
                    r_carry                    <= w_nib_cout;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_nib_cout;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - self-checking bench for cla_seq_adder
module tb_cla_seq_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp;
    int n_err;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {cout, sum}, computed as plain integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        logic [W:0] r;
        if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else    r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
        return r;
    endfunction

    // Issue one start, scramble the operand inputs during RUN, and count
    // the cycles from the start edge until done is seen (bounded).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic_add;
        int lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 16) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_run got=%b exp=1 cyc=%0d", busy, lat); end
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
        n_cmp++; if (sum !== 16'h2201) begin n_err++; $display("FAIL basic_sum got=%h exp=2201", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL basic_cout got=%b exp=0", cout); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        n_cmp++; if (sum !== 16'h2201) begin n_err++; $display("FAIL basic_sum_hold got=%h exp=2201", sum); end
    endtask

    task automatic test_carry_ripple;
        int lat;
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL ripple1_latency got=%0d exp=%0d", lat, N); end
        n_cmp++; if ({cout, sum} !== 17'h1_0000) begin n_err++; $display("FAIL ripple1 got=%b_%h exp=1_0000", cout, sum); end
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat);
        n_cmp++; if ({cout, sum} !== 17'h1_FFFF) begin n_err++; $display("FAIL ripple2 got=%b_%h exp=1_ffff", cout, sum); end
    endtask

    task automatic test_busy_protect;
        int lat;
        int n_done;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL busy_protect_dones got=%0d exp=1", n_done); end
        n_cmp++; if (sum !== 16'h0002) begin n_err++; $display("FAIL busy_protect_sum got=%h exp=0002", sum); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_protect_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        // Still inside the done cycle: request the next operation now.
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, N); end
        n_cmp++; if ({cout, sum} !== 17'h0_0100) begin n_err++; $display("FAIL b2b_result got=%b_%h exp=0_0100", cout, sum); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int n_done;
        @(negedge clk);
        a = 16'h9999; b = 16'h8888; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout got=%b exp=0", cout); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL midrst_no_activity got=%0d exp=0", n_done); end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, N); end
        n_cmp++; if ({cout, sum} !== 17'h0_0007) begin n_err++; $display("FAIL midrst_result got=%b_%h exp=0_0007", cout, sum); end
    endtask

`ifdef CLA_SEQ_SUB_EN
    task automatic test_sub;
        int lat;
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat);
        n_cmp++; if ({cout, sum} !== 17'h1_0002) begin n_err++; $display("FAIL sub1 got=%b_%h exp=1_0002", cout, sum); end
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        n_cmp++; if ({cout, sum} !== 17'h0_FFFE) begin n_err++; $display("FAIL sub2 got=%b_%h exp=0_fffe", cout, sum); end
    endtask
`endif

    task automatic test_random;
        int lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        logic [W:0]   exp_v;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            exp_v = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, lat);
            n_cmp++;
            if (lat != N || {cout, sum} !== exp_v) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b got=%b_%h lat=%0d exp=%b_%h lat=%0d",
                         i, ra, rb, rc, rs, cout, sum, lat, exp_v[W], exp_v[W-1:0], N);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset;
        test_basic_add;
        test_carry_ripple;
        test_busy_protect;
        test_back_to_back;
        test_reset_mid;
`ifdef CLA_SEQ_SUB_EN
        test_sub;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
